// File: rtl/dense_layer_if.sv
// Signal bundle for dense_layer: start/done handshake, operand buses and result bus.
// The master drives the operands and start; the slave (the layer) returns logits and status.
interface dense_layer_if #(
  parameter int WIDTH   = 16,
  parameter int IN_DIM  = 16,
  parameter int OUT_DIM = 10
);
  logic                                          start;
  logic [IN_DIM-1:0][WIDTH-1:0]                  input_data;
  logic [OUT_DIM-1:0][IN_DIM-1:0][WIDTH-1:0]     weights;
  logic [OUT_DIM-1:0][WIDTH-1:0]                 bias;
  logic [OUT_DIM-1:0][WIDTH-1:0]                 output_data;
  logic                                          done;
  logic                                          busy;
  logic                                          ovf;

  modport master (
    output start, input_data, weights, bias,
    input  output_data, done, busy, ovf
  );

  modport slave (
    input  start, input_data, weights, bias,
    output output_data, done, busy, ovf
  );
endinterface

// File: rtl/dense_layer.sv
// Fully connected layer y = W*x + b on one shared multiplier, one MAC per cycle.
// Define DENSE_LAYER_SAT_EN to clamp out-of-range logits; otherwise they wrap.
module dense_layer #(
  parameter int WIDTH             = 16,
  parameter int IN_DIM            = 16,
  parameter int OUT_DIM           = 10,
  parameter int FIXED_POINT_INDEX = 8
) (
  input logic          clk,
  input logic          reset,
  dense_layer_if.slave bus
);
  localparam int ACC_W = 2*WIDTH + $clog2(IN_DIM) + 1;
  localparam int IW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int JW    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;

  typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

  state_t                        state_q, state_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [IW-1:0]                 i_q, i_d;
  logic [JW-1:0]                 j_q, j_d;
  logic                          ovf_q, ovf_d;
  logic [OUT_DIM-1:0][WIDTH-1:0] out_q, out_d;
  logic [IN_DIM-1:0][WIDTH-1:0]  x_q, x_d;

  logic signed [WIDTH-1:0]       x_j, w_ij, b_i;
  logic signed [2*WIDTH-1:0]     x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]       prod_ext, bias_ext, pre_shift, y_full;

  // True when v does not fit a signed WIDTH-bit word.
  function automatic logic out_of_range(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-WIDTH:0] top;
    top = v[ACC_W-1:WIDTH-1];
    return !((&top) || (~|top));
  endfunction

  function automatic logic [WIDTH-1:0] fit_word(input logic signed [ACC_W-1:0] v);
`ifdef DENSE_LAYER_SAT_EN
    if (out_of_range(v))
      return v[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    return v[WIDTH-1:0];
  endfunction

  assign x_j      = x_q[j_q];
  assign w_ij     = bus.weights[i_q][j_q];
  assign b_i      = bus.bias[i_q];
  assign x_ext    = {{WIDTH{x_j[WIDTH-1]}}, x_j};
  assign w_ext    = {{WIDTH{w_ij[WIDTH-1]}}, w_ij};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign bias_ext = {{(ACC_W-WIDTH){b_i[WIDTH-1]}}, b_i} <<< FIXED_POINT_INDEX;
  assign pre_shift = acc_q + bias_ext;
  // Arithmetic shift floors toward negative infinity; no rounding term is added.
  assign y_full   = pre_shift >>> FIXED_POINT_INDEX;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    ovf_d   = ovf_q;
    out_d   = out_q;
    x_d     = x_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.input_data;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          ovf_d   = 1'b0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + prod_ext;
        if (j_q == JW'(IN_DIM-1)) begin
          j_d     = '0;
          state_d = STORE;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      STORE: begin
        out_d[i_q] = fit_word(y_full);
        if (out_of_range(y_full)) ovf_d = 1'b1;
        acc_d = '0;
        j_d   = '0;
        if (i_q == IW'(OUT_DIM-1)) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + IW'(1);
          state_d = MAC;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      ovf_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      ovf_q   <= ovf_d;
      out_q   <= out_d;
    end
  end

  // The activation copy is pure data and needs no reset.
  always_ff @(posedge clk) begin
    x_q <= x_d;
  end

  assign bus.output_data = out_q;
  assign bus.done        = (state_q == DONE);
  assign bus.busy        = (state_q == MAC) || (state_q == STORE);
  assign bus.ovf         = ovf_q;
endmodule
